// File: rtl/wfa_bram_pkg.sv
// Package: wfa_bram_pkg
// Purpose: Shared types and constants for the BRAM burst reader.
//   - burst_state_e : burst FSM states (idle, issuing reads, draining, done pulse).
//   - FIFO_DEPTH_MIN: smallest output buffer depth the reader can work with.
// Ports: none (package).
package wfa_bram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } burst_state_e;

    // Depth 2 covers one buffered word plus one read in flight; 3 or more sustains 1 word/cycle.
    localparam int unsigned FIFO_DEPTH_MIN = 2;

endpackage

// File: rtl/rd_skid_fifo.sv
// Module: rd_skid_fifo
// Purpose: Small synchronous FIFO that buffers BRAM read data ahead of the output stream.
//   Outputs come straight from registers (storage, pointers, count).
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push       write push_data this cycle (ignored when full unless popping too)
//   push_data  entry to write
//   pop        remove the head entry this cycle (ignored when empty)
//   pop_data   head entry
//   valid      FIFO is not empty
//   count      current occupancy, 0..DEPTH
module rd_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    // Push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign valid    = (count_q != '0);
    assign count    = count_q;

endmodule

// File: rtl/bram_burst_reader.sv
// Module: bram_burst_reader
// Purpose: Reads a contiguous run of words from a single-port BRAM (1-cycle registered read,
//   no read enable) and presents them on a valid/ready stream, absorbing the read latency
//   and downstream back-pressure without dropping or repeating words.
// Optional feature: define BRAM_READER_REVERSE_EN to add the `reverse` input; a burst started
//   with reverse=1 walks addresses downwards (wrapping 0 -> 2**ADDR_WIDTH-1).
// Ports:
//   clk, rst              clock, synchronous active-high reset (aborts any burst, no done)
//   start                 burst request, sampled only while idle
//   base_addr, len        first address and word count (0..2**ADDR_WIDTH)
//   reverse               (BRAM_READER_REVERSE_EN only) descending addresses, sampled with start
//   busy                  burst in progress
//   done                  one-cycle pulse once the burst has completed
//   bram_addr/wen/din     BRAM control; wen and din are tied to zero
//   bram_dout             BRAM read data, valid the cycle after the address
//   out_valid/ready/data  output stream; data is held while stalled
//   out_last              marks the final word of the burst
module bram_burst_reader
    import wfa_bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef BRAM_READER_REVERSE_EN
    input  logic                  reverse,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_wen,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

    if (FIFO_DEPTH < FIFO_DEPTH_MIN) begin : g_depth_check
        $error("bram_burst_reader: FIFO_DEPTH must be at least %0d", FIFO_DEPTH_MIN);
    end

    burst_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issue_cnt_q;
    logic                  pending_q;
    logic                  pending_last_q;
    logic                  issue;
    logic                  issue_last;
    logic                  can_issue;
    logic                  pop;
    logic [CNT_W:0]        fill;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_data;

`ifdef BRAM_READER_REVERSE_EN
    logic reverse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reverse_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            reverse_q <= reverse;
        end
    end

    assign addr_step = reverse_q ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
`else
    assign addr_step = addr_q + ADDR_WIDTH'(1);
`endif

    // A read in flight already owns a buffer slot; a same-cycle pop is not counted as space.
    assign fill       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q};
    assign can_issue  = fill < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue_last = (issue_cnt_q + LEN_W'(1)) == len_q;
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done    = 1'b0;
        busy    = (state_q == StRun) || (state_q == StDrain);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero-length burst spends one cycle in drain so done lands at C+2.
                    state_d = (len == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (len_q == '0 || (pop && out_last)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            len_q          <= '0;
            issue_cnt_q    <= '0;
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= issue;
            pending_last_q <= issue && issue_last;
            if (state_q == StIdle && start) begin
                addr_q      <= base_addr;
                len_q       <= len;
                issue_cnt_q <= '0;
            end else if (issue) begin
                addr_q      <= addr_step;
                issue_cnt_q <= issue_cnt_q + LEN_W'(1);
            end
        end
    end

    assign bram_addr = addr_q;
    assign bram_wen  = 1'b0;
    assign bram_din  = '0;

    // The read issued last cycle returns now; it is tagged with its last-word flag.
    rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pending_q),
        .push_data ({pending_last_q, bram_dout}),
        .pop       (pop),
        .pop_data  (fifo_data),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_data = fifo_data[DATA_WIDTH-1:0];
    // Stale storage after an abort must not show up as a last flag.
    assign out_last = out_valid && fifo_data[DATA_WIDTH];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Testbench for bram_burst_reader: a model BRAM preloaded with mem[i] = i ^ 16'hA5A5, an
// expected-word queue built from each burst request, and a per-cycle output check.
module tb_bram_burst_reader;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
`ifdef BRAM_READER_REVERSE_EN
    logic          reverse;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_wen;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    bram_burst_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef BRAM_READER_REVERSE_EN
        .reverse   (reverse),
`endif
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_wen  (bram_wen),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] mem [256];
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] log_data [512];
    int            exp_done = -1;
    int            done_cyc = -1;
    int            first_valid = -1;
    int            hs = 0;
    int            c_start = 0;
    int            ready_mode = 0;
    int            ready_phase = 0;
    bit            done_seen = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle registered read, no enable.
    always @(posedge clk) bram_dout <= mem[bram_addr];

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, want);
        end
    endtask

    // Output check for the current cycle, against the expected-word queue.
    task automatic check_cycle();
        logic [DW:0] e;
        if (rst) begin
            prev_stall = 1'b0;
            return;
        end
        chk("fifo_occupancy_le_depth", (int'(dut.fifo_count) <= DEPTH) ? 1 : 0, 1);
        chk("bram_write_side_zero", int'({bram_wen, bram_din}), 0);
        if (prev_stall) begin
            chk("stall_valid_held", int'(out_valid), 1);
            chk("stall_data_held", int'(out_data), int'(prev_data));
        end
        if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", int'(out_valid), 0);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                chk("out_data", int'(out_data), int'(e[DW-1:0]));
                chk("out_last", int'(out_last), int'(e[DW]));
                log_data[hs] = out_data;
                hs++;
                if (e[DW]) exp_done = cyc + 1;
            end
        end else begin
            chk("last_without_valid", int'(out_last), 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        chk("done_pulse", int'(done), (cyc == exp_done) ? 1 : 0);
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    endtask

    // Check this cycle at the falling edge, then step to 1 time unit past the next rising edge.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
        endcase
        ready_phase++;
    endtask

    task automatic begin_burst(input int b, input int l, input bit rev);
        int  a;
        bit  last;
        base_addr = AW'(b);
        len       = (AW + 1)'(l);
`ifdef BRAM_READER_REVERSE_EN
        reverse   = rev;
`endif
        start       = 1'b1;
        c_start     = cyc;
        first_valid = -1;
        done_seen   = 1'b0;
        done_cyc    = -1;
        hs          = 0;
        for (int i = 0; i < l; i++) begin
            a    = rev ? (((b - i) % 256) + 256) % 256 : (b + i) % 256;
            last = (i == l - 1);
            exp_q.push_back({last, mem[a]});
        end
        exp_done = (l == 0) ? c_start + 2 : -1;
        tick();
        start = 1'b0;
        if (l != 0) chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic finish_burst();
        int n = 0;
        while (!done_seen && n < 600) begin
            tick();
            n++;
        end
        chk("burst_completed", int'(done_seen), 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_burst(input int b, input int l, input bit rev, input int mode);
        ready_mode = mode;
        begin_burst(b, l, rev);
        finish_burst();
    endtask

    initial begin
        int n;
        int rb;
        int rl;
        bit rr;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i) ^ 16'hA5A5;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
`ifdef BRAM_READER_REVERSE_EN
        reverse   = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_bram_addr", int'(bram_addr), 0);

        // 1: basic burst, back-to-back words.
        run_burst(10, 5, 1'b0, 0);
        chk("t1_first_valid_cycle", first_valid, c_start + 3);
        chk("t1_done_cycle", done_cyc, c_start + 8);
        chk("t1_first_word", int'(log_data[0]), 'hA5AF);
        chk("t1_last_word", int'(log_data[4]), 'hA5AB);

        // 2: address wrap with no gap.
        run_burst(250, 10, 1'b0, 0);
        chk("t2_word_at_255", int'(log_data[5]), 'hA55A);
        chk("t2_word_at_0", int'(log_data[6]), 'hA5A5);
        chk("t2_done_cycle", done_cyc, c_start + 13);

        // 3: back-pressure, fixed 1-0-0-1 pattern then random.
        ready_phase = 0;
        run_burst(37, 16, 1'b0, 2);
        chk("t3_pattern_count", hs, 16);
        run_burst(200, 16, 1'b0, 1);
        chk("t3_random_count", hs, 16);

        // 4: zero-length burst.
        run_burst(5, 0, 1'b0, 0);
        chk("t4_done_cycle", done_cyc, c_start + 2);
        chk("t4_no_valid", first_valid, -1);

        // 5: reset mid-burst after three words.
        ready_mode = 0;
        begin_burst(20, 8, 1'b0);
        n = 0;
        while (hs < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_three_words_seen", (hs >= 3) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_done = -1;
        chk("t5_valid_after_rst", int'(out_valid), 0);
        chk("t5_busy_after_rst", int'(busy), 0);
        repeat (4) tick();
        run_burst(0, 2, 1'b0, 0);
        chk("t5_restart_word0", int'(log_data[0]), 'hA5A5);
        chk("t5_restart_word1", int'(log_data[1]), 'hA5A4);

`ifdef BRAM_READER_REVERSE_EN
        // 6: descending burst across address 0.
        run_burst(1, 4, 1'b1, 0);
        chk("t6_word0", int'(log_data[0]), 'hA5A4);
        chk("t6_word1", int'(log_data[1]), 'hA5A5);
        chk("t6_word2", int'(log_data[2]), 'hA55A);
        chk("t6_word3", int'(log_data[3]), 'hA55B);
`endif

        // Full-address-space burst reads every word once.
        run_burst(128, 256, 1'b0, 0);
        chk("full_count", hs, 256);
        chk("full_done_cycle", done_cyc, c_start + 259);

        // Randomized bursts.
        for (int k = 0; k < 8; k++) begin
            rb = int'($urandom_range(0, 255));
            rl = int'($urandom_range(1, 40));
`ifdef BRAM_READER_REVERSE_EN
            rr = 1'($urandom_range(0, 1));
`else
            rr = 1'b0;
`endif
            run_burst(rb, rl, rr, int'($urandom_range(0, 2)));
            chk("rand_count", hs, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
